// File: rtl/task_tx_pkg.sv
// Shared types and constants for the task result transmit framer.
//   tx_state_e   : framer FSM states
//   fifo_entry_t : one buffered task output byte plus its end-of-frame flag
//   DEF_*_BYTE   : default framing control codes
//   ESC_XOR      : mask applied to a byte that follows ESC on the wire
package task_tx_pkg;

  typedef enum logic [2:0] {IDLE, SOF, DATA, ESC, EOF} tx_state_e;

  localparam logic [7:0] DEF_SOF_BYTE = 8'hA5;
  localparam logic [7:0] DEF_EOF_BYTE = 8'h5A;
  localparam logic [7:0] DEF_ESC_BYTE = 8'h1B;
  localparam logic [7:0] ESC_XOR      = 8'h20;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/task_result_tx_framer_if.sv
// Handshake bundle of the framer.
//   i_valid/i_last/i_data : task output stream into the framer (no backpressure)
//   o_tx_valid/o_tx_data  : byte offered to the UART transmitter
//   i_tx_ready            : UART transmitter accepts the offered byte
// slave  : framer side
// master : task block / UART side
interface task_result_tx_framer_if;
  logic       i_valid;
  logic       i_last;
  logic [7:0] i_data;
  logic       o_tx_valid;
  logic       i_tx_ready;
  logic [7:0] o_tx_data;

  modport slave  (input  i_valid, i_last, i_data, i_tx_ready,
                  output o_tx_valid, o_tx_data);
  modport master (output i_valid, i_last, i_data, i_tx_ready,
                  input  o_tx_valid, o_tx_data);
endinterface

// File: rtl/task_result_tx_framer_sync_fifo.sv
// Single-clock FIFO of {last, data} entries with show-ahead read.
//   wr_en/wr_entry : push (accepted when not full, or when full and popping)
//   rd_en          : pop the head entry
//   set_last_tail  : set the last flag on the most recently written entry
//   head/head_nxt  : entry at the read pointer and the one behind it
//   level          : occupancy, 0..DEPTH
//   full/empty     : derived from level
module sync_fifo
  import task_tx_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   wr_en,
  input  fifo_entry_t            wr_entry,
  input  logic                   rd_en,
  input  logic                   set_last_tail,
  output fifo_entry_t            head,
  output fifo_entry_t            head_nxt,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  fifo_entry_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, tail_ptr, rd_ptr_nxt;
  logic          do_wr, do_rd;

  assign full       = (level == (AW+1)'(DEPTH));
  assign empty      = (level == '0);
  assign tail_ptr   = wr_ptr - AW'(1);
  assign rd_ptr_nxt = rd_ptr + AW'(1);

  // A pop in the same cycle frees a slot, so a write to a full FIFO still lands.
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr_nxt;
      level <= level + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (do_wr)              mem[wr_ptr]        <= wr_entry;
    else if (set_last_tail) mem[tail_ptr].last <= 1'b1;
  end

  assign head     = mem[rd_ptr];
  assign head_nxt = mem[rd_ptr_nxt];

endmodule

// File: rtl/task_result_tx_framer.sv
// Task result transmit framer: buffers task output bytes and sends each frame
// to the UART transmitter as SOF, byte-stuffed payload, EOF.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   tx_if          : task stream in, UART byte handshake out (slave modport)
//   o_busy         : FSM not idle or FIFO not empty
//   o_overflow     : sticky, an input byte was dropped on a full FIFO
//   o_fifo_level   : FIFO occupancy
// Only DATA_WIDTH = 8 is supported.
module task_result_tx_framer
  import task_tx_pkg::*;
#(
  parameter int         DATA_WIDTH = 8,
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] SOF_BYTE   = DEF_SOF_BYTE,
  parameter logic [7:0] EOF_BYTE   = DEF_EOF_BYTE,
  parameter logic [7:0] ESC_BYTE   = DEF_ESC_BYTE
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  task_result_tx_framer_if.slave      tx_if,
  output logic                        o_busy,
  output logic                        o_overflow,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_level
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  tx_state_e             state, state_n;
  logic                  tv, tv_n;
  logic [DATA_WIDTH-1:0] td, td_n;
  logic                  pop, xfer, drop;
  fifo_entry_t           head, head_nxt, wr_entry;
  logic                  full, empty;

  function automatic logic is_ctrl(input logic [7:0] b);
    return (b == SOF_BYTE) || (b == EOF_BYTE) || (b == ESC_BYTE);
  endfunction

  // First wire byte for a payload entry: the escape code if it needs stuffing.
  function automatic logic [7:0] wire_byte(input fifo_entry_t e);
    return is_ctrl(e.data) ? ESC_BYTE : e.data;
  endfunction

  assign wr_entry = '{last: tx_if.i_last, data: tx_if.i_data};
  assign drop     = tx_if.i_valid & full & ~pop;

  sync_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .wr_en        (tx_if.i_valid),
    .wr_entry     (wr_entry),
    .rd_en        (pop),
    .set_last_tail(drop & tx_if.i_last),
    .head         (head),
    .head_nxt     (head_nxt),
    .level        (o_fifo_level),
    .full         (full),
    .empty        (empty)
  );

  assign xfer = tv & tx_if.i_tx_ready;

  // Output byte is registered, so every transition also loads the next byte.
  // After a pop the following byte comes from head_nxt, keeping one byte per
  // cycle while the FIFO holds at least two entries.
  always_comb begin
    state_n = state;
    tv_n    = tv;
    td_n    = td;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          tv_n    = 1'b1;
          td_n    = SOF_BYTE;
          state_n = SOF;
        end
      end
      SOF: begin
        if (xfer) begin
          state_n = DATA;
          tv_n    = ~empty;
          if (!empty) td_n = wire_byte(head);
        end
      end
      DATA: begin
        if (!tv) begin
          // mid-frame stall: resume as soon as a byte arrives
          if (!empty) begin
            tv_n = 1'b1;
            td_n = wire_byte(head);
          end
        end else if (xfer) begin
          if (is_ctrl(head.data)) begin
            state_n = ESC;
            td_n    = head.data ^ ESC_XOR;
          end else begin
            pop = 1'b1;
            if (head.last) begin
              state_n = EOF;
              td_n    = EOF_BYTE;
            end else begin
              tv_n = (o_fifo_level > LW'(1));
              if (o_fifo_level > LW'(1)) td_n = wire_byte(head_nxt);
            end
          end
        end
      end
      ESC: begin
        if (xfer) begin
          pop = 1'b1;
          if (head.last) begin
            state_n = EOF;
            td_n    = EOF_BYTE;
          end else begin
            state_n = DATA;
            tv_n    = (o_fifo_level > LW'(1));
            if (o_fifo_level > LW'(1)) td_n = wire_byte(head_nxt);
          end
        end
      end
      EOF: begin
        if (xfer) begin
          // next frame already waiting: pass through IDLE without a gap
          if (!empty) begin
            state_n = SOF;
            td_n    = SOF_BYTE;
          end else begin
            state_n = IDLE;
            tv_n    = 1'b0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        tv_n    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      tv         <= 1'b0;
      td         <= '0;
      o_overflow <= 1'b0;
    end else begin
      state <= state_n;
      tv    <= tv_n;
      td    <= td_n;
      if (drop) o_overflow <= 1'b1;
    end
  end

  assign tx_if.o_tx_valid = tv;
  assign tx_if.o_tx_data  = td;
  assign o_busy           = (state != IDLE) | ~empty;

endmodule

// File: tb/tb_task_result_tx_framer.sv
module tb_task_result_tx_framer;
  import task_tx_pkg::*;

  typedef logic [7:0] bq_t[$];

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       o_busy, o_overflow;
  logic [4:0] o_fifo_level;
  logic       rdy_mode, rdy_fixed;
  int         cyc = 0;
  int         n_cmp = 0, n_err = 0;

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task_result_tx_framer_if tif();

  // ready either fixed or asserted one cycle in three
  assign tif.i_tx_ready = rdy_mode ? (cyc % 3 == 0) : rdy_fixed;

  task_result_tx_framer #(.FIFO_DEPTH(16)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .tx_if       (tif.slave),
    .o_busy      (o_busy),
    .o_overflow  (o_overflow),
    .o_fifo_level(o_fifo_level)
  );

  // transfer capture and hold-stability watch, sampled mid-cycle
  bq_t        cap;
  int         cap_cyc[$];
  logic       hold_q = 1'b0;
  logic [7:0] hold_d = 8'h00;
  int         stab_bad = 0, stab_holds = 0;

  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      hold_q <= 1'b0;
    end else begin
      if (hold_q) begin
        stab_holds <= stab_holds + 1;
        if (!(tif.o_tx_valid === 1'b1 && tif.o_tx_data === hold_d)) stab_bad <= stab_bad + 1;
      end
      if (tif.o_tx_valid && tif.i_tx_ready) begin
        cap.push_back(tif.o_tx_data);
        cap_cyc.push_back(cyc);
      end
      hold_q <= tif.o_tx_valid & ~tif.i_tx_ready;
      hold_d <= tif.o_tx_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_frame(input string tag, input int base, input bq_t exp);
    chk({tag, ".len"}, cap.size() - base, exp.size());
    foreach (exp[i])
      if (base + i < cap.size()) chk($sformatf("%s[%0d]", tag, i), cap[base+i], exp[i]);
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    tif.i_valid = 1'b1;
    tif.i_data  = d;
    tif.i_last  = l;
    @(posedge i_clk); #1;
    tif.i_valid = 1'b0;
    tif.i_last  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (o_busy && k < 300) begin
      @(posedge i_clk); #1;
      k++;
    end
    chk({tag, ".idle"}, o_busy, 0);
  endtask

  initial begin
    bq_t e;
    int  base;

    i_rst_n     = 1'b0;
    tif.i_valid = 1'b0;
    tif.i_last  = 1'b0;
    tif.i_data  = 8'h00;
    rdy_mode    = 1'b0;
    rdy_fixed   = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst.valid", tif.o_tx_valid, 0);
    chk("rst.data", tif.o_tx_data, 0);
    chk("rst.busy", o_busy, 0);
    chk("rst.ovf", o_overflow, 0);
    chk("rst.level", o_fifo_level, 0);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // basic frame and SOF latency
    base = cap.size();
    send(8'h01, 1'b0);
    chk("t1.level1", o_fifo_level, 1);
    chk("t1.novalid", tif.o_tx_valid, 0);
    send(8'h02, 1'b1);
    chk("t1.sof_valid", tif.o_tx_valid, 1);
    chk("t1.sof_data", tif.o_tx_data, 8'hA5);
    chk("t1.busy", o_busy, 1);
    wait_idle("t1");
    e = '{8'hA5, 8'h01, 8'h02, 8'h5A};
    chk_frame("t1", base, e);

    // every payload byte needs stuffing
    base = cap.size();
    send(8'hA5, 1'b0);
    send(8'h1B, 1'b0);
    send(8'h5A, 1'b1);
    wait_idle("t2");
    e = '{8'hA5, 8'h1B, 8'h85, 8'h1B, 8'h3B, 8'h1B, 8'h7A, 8'h5A};
    chk_frame("t2", base, e);
    chk("t2.ovf", o_overflow, 0);

    // sparse ready: data must hold while waiting
    base = cap.size();
    rdy_mode = 1'b1;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b1);
    wait_idle("t3");
    rdy_mode = 1'b0;
    e = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h5A};
    chk_frame("t3", base, e);
    chk("t3.stable", stab_bad, 0);
    chk("t3.held", stab_holds > 0, 1);

    // overflow: 20 bytes into 16 entries, last carried onto the tail
    base = cap.size();
    rdy_fixed = 1'b0;
    for (int i = 0; i < 20; i++) send(8'h40 + 8'(i), i == 19);
    chk("t4.level", o_fifo_level, 16);
    chk("t4.ovf", o_overflow, 1);
    chk("t4.sof_valid", tif.o_tx_valid, 1);
    chk("t4.sof_data", tif.o_tx_data, 8'hA5);
    rdy_fixed = 1'b1;
    wait_idle("t4");
    e = '{8'hA5};
    for (int i = 0; i < 16; i++) e.push_back(8'h40 + 8'(i));
    e.push_back(8'h5A);
    chk_frame("t4", base, e);
    chk("t4.stable", stab_bad, 0);

    // back-to-back single-byte frames, no gap
    base = cap.size();
    send(8'h10, 1'b1);
    send(8'h20, 1'b1);
    wait_idle("t5");
    e = '{8'hA5, 8'h10, 8'h5A, 8'hA5, 8'h20, 8'h5A};
    chk_frame("t5", base, e);
    if (cap_cyc.size() >= base + 6) chk("t5.span", cap_cyc[base+5] - cap_cyc[base], 5);
    else chk("t5.span_count", cap_cyc.size() - base, 6);
    chk("t5.ovf_sticky", o_overflow, 1);

    // reset mid-payload
    send(8'h61, 1'b0);
    send(8'h62, 1'b0);
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_rst_n = 1'b0;
    #1;
    chk("t6.rst_valid", tif.o_tx_valid, 0);
    chk("t6.rst_data", tif.o_tx_data, 0);
    chk("t6.rst_busy", o_busy, 0);
    chk("t6.rst_ovf", o_overflow, 0);
    chk("t6.rst_level", o_fifo_level, 0);
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    base = cap.size();
    send(8'h33, 1'b1);
    wait_idle("t6");
    e = '{8'hA5, 8'h33, 8'h5A};
    chk_frame("t6", base, e);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
